therm_enc_pipe: RTL and testbench
=================================

# therm_enc_pipe

Pipelined, parametrised thermometer-to-binary encoder for the flash ADC back end. It takes the active-low comparator word of an N-bit flash converter and applies optional 3-input majority bubble correction. It then encodes the word to binary, flags non-thermometer codes and holds the last good code on error. It replaces the fixed 4-bit encoder between the comparator latch bank and the digital output register.

## Interface
- NBITS, 4, output code width; comparator count LEVELS = 2^NBITS-1 (derived, not overridable)
- CNT_W, 16, width of the error counter
- clk  in  1  sample clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  y carries a new sample this cycle
- y  in  LEVELS  comparator outputs, active-low: bit i = 0 means input above threshold i
- err_clr  in  1  synchronous clear of err_cnt
- code  out  NBITS  binary conversion result
- out_valid  out  1  code/code_err valid this cycle
- code_err  out  1  sample was not a valid thermometer code after correction
- err_cnt  out  CNT_W  saturating count of errored samples

## Operation
- Internal word t = ~y; valid thermometer = ones contiguous from bit 0 (t = 2^k-1, k = 0..LEVELS).
- Stage 0: capture y and in_valid when in_valid=1; the valid bit always follows in_valid.
- Stage 1: bubble correction, t'[i] = maj(t[i-1], t[i], t[i+1]), padding t[-1]=1, t[LEVELS]=0. Uses raw neighbours only, not a cascade.
- Stage 2, encode: k = popcount(t').
  - If t' is a valid thermometer: code = k, code_err=0, last_good <= k.
  - Otherwise: code = last_good, code_err=1, err_cnt increments.
- All-ones y gives code 0. All-zeros y gives code 2^NBITS-1.
- err_cnt saturates at 2^CNT_W-1 with no wrap.
- err_clr sets err_cnt to 0. If err_clr and an errored output coincide, err_cnt becomes 1.
- No backpressure: the output is a stream and the consumer must accept every out_valid.
- Slots with in_valid=0 propagate as bubbles. They do not change code, last_good or err_cnt.

## Timing
- Fixed latency 3: in_valid at edge N gives out_valid, code and code_err registered at edge N+3.
- Throughput 1 sample/cycle; back-to-back in_valid is supported.
- code, code_err and last_good hold between valid slots.
- Reset values: code=0, out_valid=0, code_err=0, err_cnt=0, last_good=0, all stage valids 0.
- Reset mid-stream discards in-flight samples; no out_valid for them after rst deasserts.
- First sample after reset that errors outputs code 0 (last_good reset value).

## Configuration
- THERM_BUBBLE_CORR_EN
  - Defined: stage 1 applies majority correction as above.
  - Undefined: stage 1 is a plain register (t' = t). Any bubble is flagged as code_err.
  - Latency stays 3 cycles in both builds.

## Structure
- Package therm_pkg holds:
  - localparam function levels(nbits) = 2^nbits-1
  - popcount and is_therm functions, parametrised on width
  - typedef of the stage valid/data record
- Sub-module therm_bubble_fix (combinational majority network, LEVELS wide, macro-guarded body), instantiated in stage 1.
- Top module therm_enc_pipe holds the pipeline registers, encoder, hold logic and counter.

## Test plan
- NBITS=4, sweep y over all 16 valid codes (15'h7FFF … 15'h0000), one per cycle -> code 0..15 in order, each 3 cycles after input, code_err=0; y=15'h7F00 -> code 8.
- Bubble: y=15'b111111111110100 with THERM_BUBBLE_CORR_EN -> code 3, code_err=0; without macro -> code_err=1, code=previous good value.
- Uncorrectable: after a good code 5, y=15'h7FCC -> code 5, code_err=1, err_cnt +1.
- CNT_W=2: five errored samples -> err_cnt 1,2,3,3,3. err_clr together with an error -> err_cnt=1.
- Gapped in_valid pattern 1,0,1,1,0 -> out_valid pattern identical, delayed 3 cycles; outputs hold during the gaps.
- rst asserted with 2 samples in flight -> all outputs 0 immediately; no out_valid after release until a new in_valid plus 3 cycles.

Source files
------------

// File: rtl/therm_pkg.sv
// Shared types and helpers for the thermometer encoder pipeline.
// Words are carried zero-padded to MAX_W bits, so the helpers work for any NBITS up to MAX_NBITS.
package therm_pkg;

   localparam int MAX_NBITS = 8;
   localparam int MAX_W     = (1 << MAX_NBITS) - 1;

   typedef logic [MAX_W-1:0] word_t;

   // One pipeline slot: the valid bit plus the (padded) thermometer word it carries.
   typedef struct packed {
      logic  valid;
      word_t word;
   } stage_t;

   function automatic int levels(input int nbits);
      return (1 << nbits) - 1;
   endfunction

   function automatic int popcount(input word_t v);
      int n;
      n = 0;
      for (int i = 0; i < MAX_W; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

   // Ones contiguous from bit 0 is exactly the case where v+1 shares no set bit with v.
   function automatic logic is_therm(input word_t v);
      return (v & (v + word_t'(1))) == '0;
   endfunction

endpackage

// File: rtl/therm_enc_pipe_if.sv
// Sample stream into the encoder and result stream out of it; no backpressure.
interface therm_enc_pipe_if #(
   parameter int NBITS = 4,
   parameter int CNT_W = 16
);
   import therm_pkg::*;

   localparam int LEVELS = levels(NBITS);

   logic              in_valid;
   logic [LEVELS-1:0] y;
   logic              err_clr;
   logic [NBITS-1:0]  code;
   logic              out_valid;
   logic              code_err;
   logic [CNT_W-1:0]  err_cnt;

   modport master (
      output in_valid, y, err_clr,
      input  code, out_valid, code_err, err_cnt
   );

   modport slave (
      input  in_valid, y, err_clr,
      output code, out_valid, code_err, err_cnt
   );

endinterface

// File: rtl/therm_bubble_fix.sv
// Combinational 3-input majority bubble filter over a thermometer word.
// THERM_BUBBLE_CORR_EN enables the filter; otherwise the word passes through unchanged.
module therm_bubble_fix #(
   parameter int W = 15
) (
   input  logic [W-1:0] i_t,
   output logic [W-1:0] o_t
);

`ifdef THERM_BUBBLE_CORR_EN
   // Pad below with 1 and above with 0; each output looks only at raw neighbours.
   logic [W+1:0] w_pad;
   assign w_pad = {1'b0, i_t, 1'b1};

   for (genvar gi = 0; gi < W; gi++) begin : g_maj
      assign o_t[gi] = (w_pad[gi]   & w_pad[gi+1]) |
                       (w_pad[gi]   & w_pad[gi+2]) |
                       (w_pad[gi+1] & w_pad[gi+2]);
   end
`else
   assign o_t = i_t;
`endif

endmodule

// File: rtl/therm_enc_pipe.sv
// Pipelined thermometer-to-binary encoder: capture, bubble fix, encode, output/hold.
// Optional majority correction is selected by THERM_BUBBLE_CORR_EN.
module therm_enc_pipe #(
   parameter int NBITS = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   therm_enc_pipe_if.slave  io_bus
);
   import therm_pkg::*;

   localparam int LEVELS = levels(NBITS);

   logic [LEVELS-1:0] w_t_in;
   word_t             w_fix;
   logic              w_err_evt;

   stage_t            r_s0;
   stage_t            r_s1;
   logic              r_s2_valid;
   logic              r_s2_ok;
   logic [NBITS-1:0]  r_s2_k;
   logic              r_out_valid;
   logic              r_code_err;
   logic [NBITS-1:0]  r_code;
   logic [NBITS-1:0]  r_last_good;
   logic [CNT_W-1:0]  r_err_cnt;

   // Invert before widening so the padding above LEVELS stays zero.
   assign w_t_in = ~io_bus.y;

   // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s0 <= '0;
      end else begin
         r_s0.valid <= io_bus.in_valid;
         if (io_bus.in_valid) r_s0.word <= MAX_W'(w_t_in);
      end
   end

   therm_bubble_fix #(.W(MAX_W)) u_bubble_fix (
      .i_t (r_s0.word),
      .o_t (w_fix)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= '0;
      end else begin
         r_s1.valid <= r_s0.valid;
         if (r_s0.valid) r_s1.word <= w_fix;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_ok    <= 1'b0;
         r_s2_k     <= '0;
      end else begin
         r_s2_valid <= r_s1.valid;
         if (r_s1.valid) begin
            r_s2_ok <= is_therm(r_s1.word);
            r_s2_k  <= NBITS'(popcount(r_s1.word));
         end
      end
   end

   // Output register: a good code updates last_good, a bad one replays it; idle slots hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_code_err  <= 1'b0;
         r_code      <= '0;
         r_last_good <= '0;
      end else begin
         r_out_valid <= r_s2_valid;
         if (r_s2_valid) begin
            if (r_s2_ok) begin
               r_code      <= r_s2_k;
               r_code_err  <= 1'b0;
               r_last_good <= r_s2_k;
            end else begin
               r_code     <= r_last_good;
               r_code_err <= 1'b1;
            end
         end
      end
   end

   assign w_err_evt = r_s2_valid & ~r_s2_ok;

   // A clear on the same edge as an error leaves the count at one, not zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err_cnt <= '0;
      end else if (io_bus.err_clr) begin
         r_err_cnt <= CNT_W'(w_err_evt);
      end else if (w_err_evt && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 1'b1;
      end
   end

   assign io_bus.code      = r_code;
   assign io_bus.out_valid = r_out_valid;
   assign io_bus.code_err  = r_code_err;
   assign io_bus.err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_therm_enc_pipe.sv
// Directed bench for therm_enc_pipe (NBITS=4, CNT_W=2) with a latency-tagged scoreboard.
module tb_therm_enc_pipe;

   localparam int NBITS = 4;
   localparam int CNT_W = 2;

   typedef struct {
      int         due;
      logic [3:0] code;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   therm_enc_pipe_if #(.NBITS(NBITS), .CNT_W(CNT_W)) bus ();

   therm_enc_pipe #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [3:0] m_last_good;
   logic [3:0] m_code;
   logic       m_err;
   int         m_cnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
      end
   endtask

   // Reference: explicit majority vote, then a scan for a 1 above a 0.
   function automatic void model_push(input logic [14:0] yy, input int due);
      logic [14:0] t;
      logic [14:0] c;
      logic        lo, hi, ok, seen0;
      int          n;
      exp_t        e;
      t = ~yy;
      for (int i = 0; i < 15; i++) begin
         lo = (i == 0)  ? 1'b1 : t[i-1];
         hi = (i == 14) ? 1'b0 : t[i+1];
`ifdef THERM_BUBBLE_CORR_EN
         c[i] = (int'(lo) + int'(t[i]) + int'(hi)) >= 2;
`else
         c[i] = t[i] | (lo & hi & 1'b0);
`endif
      end
      n = 0; ok = 1'b1; seen0 = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (c[i]) begin
            n++;
            if (seen0) ok = 1'b0;
         end else begin
            seen0 = 1'b1;
         end
      end
      e.due = due;
      if (ok) begin
         e.code = 4'(n);
         e.err  = 1'b0;
         m_last_good = 4'(n);
      end else begin
         e.code = m_last_good;
         e.err  = 1'b1;
      end
      sb.push_back(e);
   endfunction

   // One clock: drive at negedge, push at the sampling edge, compare 1 ns later.
   task automatic drive(input logic v, input logic [14:0] yy, input logic clr);
      exp_t e;
      logic ev;
      bus.in_valid = v;
      bus.y        = yy;
      bus.err_clr  = clr;
      @(posedge clk);
      cyc++;
      if (v) model_push(yy, cyc + 3);
      #1;
      ev = (sb.size() > 0) && (sb[0].due == cyc);
      check("out_valid", bus.out_valid, ev);
      e.err = 1'b0;
      if (ev) begin
         e = sb.pop_front();
         m_code = e.code;
         m_err  = e.err;
      end
      if (clr) m_cnt = (ev && e.err) ? 1 : 0;
      else if (ev && e.err && m_cnt < 3) m_cnt++;
      check("code", bus.code, m_code);
      check("code_err", bus.code_err, m_err);
      check("err_cnt", bus.err_cnt, m_cnt);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.err_clr  = 1'b0;
      #1;
      check("rst_code", bus.code, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_code_err", bus.code_err, 0);
      check("rst_err_cnt", bus.err_cnt, 0);
      sb.delete();
      m_last_good = '0; m_code = '0; m_err = 1'b0; m_cnt = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 15'h7FFF, 1'b0);
   endtask

   logic [14:0] yy;
   int          k, b;

   initial begin
      bus.y = 15'h7FFF;
      do_reset();

      // All sixteen valid codes back to back, then a mid-scale code.
      for (int s = 0; s < 16; s++) begin
         yy = 15'h7FFF << s;
         drive(1'b1, yy, 1'b0);
      end
      drive(1'b1, 15'h7F00, 1'b0);
      idle(3);
      check("mid_code", bus.code, 8);

      // Single bubble below the top of a code-3 word.
      drive(1'b1, 15'b111111111110100, 1'b0);
      idle(3);
`ifdef THERM_BUBBLE_CORR_EN
      check("bubble_code", bus.code, 3);
      check("bubble_err", bus.code_err, 0);
`else
      check("bubble_code", bus.code, 8);
      check("bubble_err", bus.code_err, 1);
`endif

      // Uncorrectable word replays the previous good code.
      drive(1'b1, 15'h7FE0, 1'b0);
      drive(1'b1, 15'h7FCC, 1'b0);
      idle(3);
      check("uncorr_code", bus.code, 5);
      check("uncorr_err", bus.code_err, 1);

      // Saturation of the 2-bit counter.
      drive(1'b0, 15'h7FFF, 1'b1);
      for (int s = 0; s < 5; s++) drive(1'b1, 15'h7FCC, 1'b0);
      idle(3);
      check("sat_cnt", bus.err_cnt, 3);

      // Clear on the same edge as an errored output.
      drive(1'b1, 15'h7FCC, 1'b0);
      idle(2);
      drive(1'b0, 15'h7FFF, 1'b1);
      check("clr_with_err", bus.err_cnt, 1);

      // Gapped valid pattern 1,0,1,1,0.
      drive(1'b1, 15'h7FFC, 1'b0);
      drive(1'b0, 15'h0000, 1'b0);
      drive(1'b1, 15'h7E00, 1'b0);
      drive(1'b1, 15'h7000, 1'b0);
      drive(1'b0, 15'h0000, 1'b0);
      idle(4);
      check("gap_hold", bus.code, 12);

      // Reset with two samples in flight.
      drive(1'b1, 15'h7FF0, 1'b0);
      drive(1'b1, 15'h7FC0, 1'b0);
      do_reset();
      idle(5);
      drive(1'b1, 15'h7FF8, 1'b0);
      idle(3);
      check("post_rst_code", bus.code, 3);

      // Thermometer codes with an occasional flipped bit.
      for (int n = 0; n < 20; n++) begin
         k = $urandom_range(0, 15);
         b = $urandom_range(0, 14);
         yy = 15'h7FFF << k;
         if ($urandom_range(0, 3) == 0) yy[b] = ~yy[b];
         drive(1'b1, yy, 1'b0);
      end

      for (int i = 0; i < 8 && sb.size() > 0; i++) idle(1);
      check("drain", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
